// File: rtl/sync_debounce_edge.sv
// Conditions an asynchronous single-bit input: synchroniser chain, stability
// debounce, one-cycle rise/fall strobes and a saturating rising-edge counter.
//
// Ports:
//   i_clk       system clock, all logic on the rising edge
//   i_rstn      synchronous active-low reset
//   i_d         asynchronous raw input
//   i_clr       synchronous clear of o_edge_cnt (wins over a same-cycle rise)
//   o_q         debounced, synchronised level
//   o_rise      one-cycle pulse on the edge o_q goes 0->1
//   o_fall      one-cycle pulse on the edge o_q goes 1->0
//   o_busy      high while a level change is pending (debounce count non-zero)
//   o_edge_cnt  saturating count of o_rise pulses
//
// Legal parameters: SYNC_STAGES 2..4, DEB_CYCLES >= 1.
module sync_debounce_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_d,
  input  logic             i_clr,
  output logic             o_q,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_edge_cnt
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic                   s_sync;

  // Synchroniser shift chain; only the last stage is used downstream.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
  assign s_sync = sync_q[SYNC_STAGES-1];

  // Debounce: the level only moves after DEB_CYCLES consecutive disagreements.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    if (s_sync == level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      level_d   = s_sync;
      deb_cnt_d = '0;
      rise_d    = s_sync;
      fall_d    = ~s_sync;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end
    busy_d = (deb_cnt_d != '0);
  end

  // Rising-edge counter: clear has priority, saturates instead of wrapping.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (i_clr) begin
      edge_cnt_d = '0;
    end else if (rise_d && (edge_cnt_q != CNT_MAX)) begin
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      sync_q     <= '0;
      deb_cnt_q  <= '0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      busy_q     <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      sync_q     <= sync_d;
      deb_cnt_q  <= deb_cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      busy_q     <= busy_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign o_q        = level_q;
  assign o_rise     = rise_q;
  assign o_fall     = fall_q;
  assign o_busy     = busy_q;
  assign o_edge_cnt = edge_cnt_q;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed bench for sync_debounce_edge: default instance plus a CNT_W=2
// instance for counter saturation. Both share i_d/i_rstn; clears are separate.
module tb_sync_debounce_edge;

  logic       i_clk = 1'b0;
  logic       i_rstn, i_d, i_clr, sat_clr;
  logic       q, rise, fall, busy;
  logic [7:0] cnt;
  logic       sq, srise, sfall, sbusy;
  logic [1:0] scnt;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 i_clk = ~i_clk;

  sync_debounce_edge dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_d(i_d), .i_clr(i_clr),
    .o_q(q), .o_rise(rise), .o_fall(fall), .o_busy(busy), .o_edge_cnt(cnt)
  );

  sync_debounce_edge #(.CNT_W(2)) dut_sat (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_d(i_d), .i_clr(sat_clr),
    .o_q(sq), .o_rise(srise), .o_fall(sfall), .o_busy(sbusy), .o_edge_cnt(scnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // i_d has just changed to new_q: level holds for edges 0..4 and flips on
  // edge 5 with a one-cycle strobe; busy is high after edges 2, 3 and 4.
  task automatic wait_edge(input string tag, input logic new_q, input logic clr_at_pulse);
    for (int e = 0; e < 5; e++) begin
      step();
      check({tag, "_q_hold"}, 32'(q), 32'(!new_q));
      check({tag, "_rise_hold"}, 32'(rise), 32'(0));
      check({tag, "_fall_hold"}, 32'(fall), 32'(0));
      check({tag, "_busy_hold"}, 32'(busy), 32'((e >= 2) ? 1 : 0));
    end
    i_clr = clr_at_pulse;
    step();
    i_clr = 1'b0;
    check({tag, "_q_new"}, 32'(q), 32'(new_q));
    check({tag, "_rise_pulse"}, 32'(rise), 32'(new_q));
    check({tag, "_fall_pulse"}, 32'(fall), 32'(!new_q));
    check({tag, "_busy_done"}, 32'(busy), 32'(0));
    check({tag, "_sat_q"}, 32'(sq), 32'(new_q));
    check({tag, "_sat_rise"}, 32'(srise), 32'(new_q));
    check({tag, "_sat_fall"}, 32'(sfall), 32'(!new_q));
    check({tag, "_sat_busy"}, 32'(sbusy), 32'(0));
  endtask

  task automatic hold(input string tag, input logic lvl, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      check({tag, "_q_stable"}, 32'(q), 32'(lvl));
      check({tag, "_no_rise"}, 32'(rise), 32'(0));
      check({tag, "_no_fall"}, 32'(fall), 32'(0));
      check({tag, "_idle"}, 32'(busy), 32'(0));
    end
  endtask

  task automatic toggle(input string tag, input logic new_q, input logic clr_at_pulse);
    i_d = new_q;
    wait_edge(tag, new_q, clr_at_pulse);
    hold(tag, new_q, 4);
  endtask

  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    i_rstn  = 1'b0;
    i_d     = 1'b1;
    i_clr   = 1'b0;
    sat_clr = 1'b0;

    // Reset held with i_d=1: everything stays at zero.
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_q", 32'(q), 32'(0));
      check("rst_rise", 32'(rise), 32'(0));
      check("rst_fall", 32'(fall), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_cnt", 32'(cnt), 32'(0));
      check("rst_sat_cnt", 32'(scnt), 32'(0));
    end
    i_rstn = 1'b1;
    wait_edge("rst_exit", 1'b1, 1'b0);
    check("rst_exit_cnt", 32'(cnt), 32'(1));
    hold("rst_exit", 1'b1, 4);

    // Clean toggles.
    toggle("pre_fall", 1'b0, 1'b0);
    toggle("clean_rise", 1'b1, 1'b0);
    check("clean_rise_cnt", 32'(cnt), 32'(2));
    check("clean_rise_sat_cnt", 32'(scnt), 32'(2));
    hold("clean_rise_tail", 1'b1, 6);
    toggle("clean_fall", 1'b0, 1'b0);
    hold("clean_fall_tail", 1'b0, 6);
    check("clean_fall_cnt", 32'(cnt), 32'(2));

    // Three-cycle glitch is rejected; busy shows the aborted attempt.
    i_d = 1'b1;
    for (int e = 0; e < 8; e++) begin
      if (e == 3) i_d = 1'b0;
      step();
      check("glitch_q", 32'(q), 32'(0));
      check("glitch_rise", 32'(rise), 32'(0));
      check("glitch_busy", 32'(busy), 32'((e >= 2 && e <= 4) ? 1 : 0));
    end
    check("glitch_cnt", 32'(cnt), 32'(2));

    // Clear on the same edge as a rise wins; a later rise counts from zero.
    toggle("clr_rise", 1'b1, 1'b1);
    check("clr_prio_cnt", 32'(cnt), 32'(0));
    check("clr_prio_sat_cnt", 32'(scnt), 32'(3));
    toggle("clr_fall", 1'b0, 1'b0);
    toggle("clr_rise2", 1'b1, 1'b0);
    check("clr_after_cnt", 32'(cnt), 32'(1));
    check("clr_after_sat_cnt", 32'(scnt), 32'(3));
    toggle("clr_fall2", 1'b0, 1'b0);

    // Saturation on the 2-bit counter.
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("sat_clear", 32'(scnt), 32'(0));
    check("sat_clear_main_cnt", 32'(cnt), 32'(1));
    for (int k = 0; k < 5; k++) begin
      toggle("sat_rise", 1'b1, 1'b0);
      check("sat_cnt", 32'(scnt), 32'(sat_exp[k]));
      check("sat_main_cnt", 32'(cnt), 32'(2 + k));
      toggle("sat_fall", 1'b0, 1'b0);
    end

    // Reset in the middle of a debounce restarts the whole latency.
    i_d = 1'b1;
    repeat (3) step();
    check("midrst_busy_before", 32'(busy), 32'(1));
    i_rstn = 1'b0;
    step();
    i_rstn = 1'b1;
    check("midrst_q", 32'(q), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_rise", 32'(rise), 32'(0));
    check("midrst_cnt", 32'(cnt), 32'(0));
    check("midrst_sat_cnt", 32'(scnt), 32'(0));
    wait_edge("post_rst", 1'b1, 1'b0);
    check("post_rst_cnt", 32'(cnt), 32'(1));
    check("post_rst_sat_cnt", 32'(scnt), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
